// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the fetch address, drives a req/ack imem port and
// presents instruction/pc/pc_1 to decode through a registered slot with a 1-entry skid.
module if_stage #(
  parameter int unsigned            ADDR_WIDTH = 32,
  parameter int unsigned            DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0]  RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] next_pc,
  input  logic                  pc_load,
  input  logic                  stall,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_ack,
  input  logic [DATA_WIDTH-1:0] imem_data,
  output logic [DATA_WIDTH-1:0] instruction,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [ADDR_WIDTH-1:0] pc_1,
  output logic                  valid
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_HOLD,
    S_DROP
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [ADDR_WIDTH-1:0]   pend_q, pend_d;
  logic                    req_q, req_d;
  logic                    valid_q, valid_d;
  logic [DATA_WIDTH-1:0]   instr_q, instr_d;
  logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
  logic [ADDR_WIDTH-1:0]   pc1_q, pc1_d;
  logic [DATA_WIDTH-1:0]   skid_data_q, skid_data_d;
  logic [ADDR_WIDTH-1:0]   skid_pc_q, skid_pc_d;
  logic [ADDR_WIDTH-1:0]   skid_pc1_q, skid_pc1_d;

  logic                    slot_free;
  logic [ADDR_WIDTH-1:0]   addr_inc;

  assign slot_free = !valid_q || !stall;
  assign addr_inc  = addr_q + ADDR_ONE;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    pend_d      = pend_q;
    valid_d     = valid_q;
    instr_d     = instr_q;
    pc_d        = pc_q;
    pc1_d       = pc1_q;
    skid_data_d = skid_data_q;
    skid_pc_d   = skid_pc_q;
    skid_pc1_d  = skid_pc1_q;

    // A consumed slot empties unless something below refills it this edge.
    if (valid_q && !stall) begin
      valid_d = 1'b0;
    end

    unique case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
        if (pc_load) begin
          addr_d = next_pc;
        end
      end

      S_REQ: begin
        if (imem_ack) begin
          if (pc_load) begin
            addr_d = next_pc;
          end else if (slot_free) begin
            instr_d = imem_data;
            pc_d    = addr_q;
            pc1_d   = addr_inc;
            valid_d = 1'b1;
            addr_d  = addr_inc;
          end else begin
            skid_data_d = imem_data;
            skid_pc_d   = addr_q;
            skid_pc1_d  = addr_inc;
            addr_d      = addr_inc;
            state_d     = S_HOLD;
          end
        end else if (pc_load) begin
          // The request cannot be withdrawn mid-handshake; finish it in DROP.
          pend_d  = next_pc;
          state_d = S_DROP;
        end
      end

      S_HOLD: begin
        if (pc_load) begin
          addr_d  = next_pc;
          state_d = S_REQ;
        end else if (slot_free) begin
          instr_d = skid_data_q;
          pc_d    = skid_pc_q;
          pc1_d   = skid_pc1_q;
          valid_d = 1'b1;
          state_d = S_REQ;
        end
      end

      S_DROP: begin
        if (pc_load) begin
          pend_d = next_pc;
        end
        if (imem_ack) begin
          addr_d  = pc_load ? next_pc : pend_q;
          state_d = S_REQ;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (pc_load) begin
      valid_d = 1'b0;
    end

    req_d = (state_d == S_REQ) || (state_d == S_DROP);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      addr_q      <= RESET_PC;
      pend_q      <= RESET_PC;
      req_q       <= 1'b0;
      valid_q     <= 1'b0;
      instr_q     <= '0;
      pc_q        <= '0;
      pc1_q       <= '0;
      skid_data_q <= '0;
      skid_pc_q   <= '0;
      skid_pc1_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      pend_q      <= pend_d;
      req_q       <= req_d;
      valid_q     <= valid_d;
      instr_q     <= instr_d;
      pc_q        <= pc_d;
      pc1_q       <= pc1_d;
      skid_data_q <= skid_data_d;
      skid_pc_q   <= skid_pc_d;
      skid_pc1_q  <= skid_pc1_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign instruction = instr_q;
  assign pc          = pc_q;
  assign pc_1        = pc1_q;
  assign valid       = valid_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: memory returns addr*0x10, acking combinationally when enabled.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] next_pc;
  logic        pc_load;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic [31:0] pc_1;
  logic        valid;
  logic        ack_en;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  if_stage #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .RESET_PC   (32'h0)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .next_pc     (next_pc),
    .pc_load     (pc_load),
    .stall       (stall),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_data   (imem_data),
    .instruction (instruction),
    .pc          (pc),
    .pc_1        (pc_1),
    .valid       (valid)
  );

  always #5 clk = ~clk;

  assign imem_ack  = ack_en & imem_req;
  assign imem_data = imem_addr << 4;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_slot(input string tag, input logic [31:0] e_pc, input logic [31:0] e_instr);
    check_eq({tag, ".valid"}, {31'b0, valid}, 32'h1);
    check_eq({tag, ".pc"}, pc, e_pc);
    check_eq({tag, ".pc_1"}, pc_1, e_pc + 32'h1);
    check_eq({tag, ".instr"}, instruction, e_instr);
  endtask

  initial begin
    reset   = 1'b0;
    next_pc = '0;
    pc_load = 1'b0;
    stall   = 1'b0;
    ack_en  = 1'b1;

    // Reset and start-up streaming
    repeat (3) tick();
    check_eq("rst.req",   {31'b0, imem_req}, 32'h0);
    check_eq("rst.addr",  imem_addr, 32'h0);
    check_eq("rst.valid", {31'b0, valid}, 32'h0);
    check_eq("rst.pc",    pc, 32'h0);
    check_eq("rst.instr", instruction, 32'h0);
    reset = 1'b1;
    tick();
    check_eq("start.req",  {31'b0, imem_req}, 32'h1);
    check_eq("start.addr", imem_addr, 32'h0);
    check_eq("start.valid", {31'b0, valid}, 32'h0);
    tick();
    check_slot("s0", 32'h0, 32'h00);
    tick();
    check_slot("s1", 32'h1, 32'h10);
    tick();
    check_slot("s2", 32'h2, 32'h20);

    // Stall for 4 edges: pc=2 held, addr 3 goes to the skid buffer
    stall = 1'b1;
    tick();
    check_slot("hold0", 32'h2, 32'h20);
    check_eq("hold0.req", {31'b0, imem_req}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_slot("holdN", 32'h2, 32'h20);
      check_eq("holdN.req", {31'b0, imem_req}, 32'h0);
    end
    stall = 1'b0;
    tick();
    check_slot("skid3", 32'h3, 32'h30);
    check_eq("skid3.addr", imem_addr, 32'h4);
    tick();
    check_slot("s4", 32'h4, 32'h40);

    // Redirect while the addr-5 request is outstanding
    check_eq("pre_drop.addr", imem_addr, 32'h5);
    ack_en  = 1'b0;
    pc_load = 1'b1;
    next_pc = 32'h40;
    tick();
    pc_load = 1'b0;
    check_eq("drop.valid", {31'b0, valid}, 32'h0);
    check_eq("drop.req",   {31'b0, imem_req}, 32'h1);
    check_eq("drop.addr",  imem_addr, 32'h5);
    tick();
    check_eq("drop2.addr",  imem_addr, 32'h5);
    check_eq("drop2.valid", {31'b0, valid}, 32'h0);
    ack_en = 1'b1;
    tick();
    check_eq("redir.addr",  imem_addr, 32'h40);
    check_eq("redir.valid", {31'b0, valid}, 32'h0);
    tick();
    check_slot("r40", 32'h40, 32'h400);

    // Redirect coinciding with ack: data discarded
    pc_load = 1'b1;
    next_pc = 32'h100;
    tick();
    pc_load = 1'b0;
    check_eq("ldack.addr",  imem_addr, 32'h100);
    check_eq("ldack.valid", {31'b0, valid}, 32'h0);
    tick();
    check_slot("r100", 32'h100, 32'h1000);

    // Redirect beats stall, and the target wraps
    stall   = 1'b1;
    pc_load = 1'b1;
    next_pc = 32'hFFFF_FFFF;
    tick();
    stall   = 1'b0;
    pc_load = 1'b0;
    check_eq("ldstall.valid", {31'b0, valid}, 32'h0);
    check_eq("ldstall.addr",  imem_addr, 32'hFFFF_FFFF);
    tick();
    check_eq("wrap.valid", {31'b0, valid}, 32'h1);
    check_eq("wrap.pc",    pc, 32'hFFFF_FFFF);
    check_eq("wrap.pc_1",  pc_1, 32'h0);
    check_eq("wrap.instr", instruction, 32'hFFFF_FFF0);
    check_eq("wrap.addr",  imem_addr, 32'h0);

    // Reset while in DROP with pending 0x80
    ack_en  = 1'b0;
    pc_load = 1'b1;
    next_pc = 32'h80;
    tick();
    pc_load = 1'b0;
    check_eq("drop80.valid", {31'b0, valid}, 32'h0);
    check_eq("drop80.req",   {31'b0, imem_req}, 32'h1);
    reset = 1'b0;
    tick();
    check_eq("midrst.req",   {31'b0, imem_req}, 32'h0);
    check_eq("midrst.valid", {31'b0, valid}, 32'h0);
    check_eq("midrst.pc",    pc, 32'h0);
    reset  = 1'b1;
    ack_en = 1'b1;
    tick();
    check_eq("restart.req",  {31'b0, imem_req}, 32'h1);
    check_eq("restart.addr", imem_addr, 32'h0);
    tick();
    check_slot("restart0", 32'h0, 32'h0);
    tick();
    check_slot("restart1", 32'h1, 32'h10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
